// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART serial port: FSM state encodings,
// a clog2 helper for counter/pointer widths and default parameter values.
package uart_pkg;

   localparam int unsigned DefDataW     = 8;
   localparam int unsigned DefClkPerBit = 16;
   localparam int unsigned DefFifoDepth = 4;

   // StBreak is the RX-only wait-for-line-high state after a framing error.
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4,
      StBreak  = 3'd5
   } uart_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) res++;
      return (res == 0) ? 1 : res;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for the UART; pointers carry an extra wrap bit to tell full from empty.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W     = DefDataW,
   parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              ovf_o
);

   localparam int unsigned PtrW = clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW:0]     wptr_q;
   logic [PtrW:0]     rptr_q;
   logic              do_push;
   logic              do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                    (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

   // A pop in the same cycle frees the slot, so a push while full still lands.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign ovf_o   = push_i && !do_push;

   assign rdata_o = empty_o ? '0 : mem_q[rptr_q[PtrW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/uart_serial_port.sv
// Full-duplex UART with single-entry transmitter and FIFO-backed receiver.
// Define UART_PARITY_EN to add an even-parity bit on both directions.
module uart_serial_port
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W      = DefDataW,
   parameter int unsigned CLK_PER_BIT = DefClkPerBit,
   parameter int unsigned FIFO_DEPTH  = DefFifoDepth
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              LSIN,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              OSOUT,
   output logic [DATA_W-1:0] rx_data,
   input  logic              rxin,
   output logic              txout,
   output logic              TXF,
   output logic              RXF,
   output logic              rx_ovf,
   output logic              rx_ferr,
   output logic              rx_perr,
   input  logic              clr_err
);

   localparam int unsigned CntW = clog2(CLK_PER_BIT);
   localparam int unsigned BitW = clog2(DATA_W);
   localparam logic [CntW-1:0] CntLast = CntW'(CLK_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLK_PER_BIT / 2 - 1);
   localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

   uart_state_e       tx_state_q;
   logic [CntW-1:0]   tx_cnt_q;
   logic [BitW-1:0]   tx_bit_q;
   logic [DATA_W-1:0] tx_shift_q;
   logic              txout_q;
   logic              tx_busy_q;
`ifdef UART_PARITY_EN
   logic              tx_par_q;
`endif

   always_ff @(posedge clk) begin
      if (RESET) begin
         tx_state_q <= StIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txout_q    <= 1'b1;
         tx_busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
         tx_par_q   <= 1'b0;
`endif
      end else begin
         case (tx_state_q)
            StIdle: begin
               if (LSIN) begin
                  tx_shift_q <= tx_data;
`ifdef UART_PARITY_EN
                  tx_par_q   <= ^tx_data;
`endif
                  txout_q    <= 1'b0;
                  tx_busy_q  <= 1'b1;
                  tx_cnt_q   <= '0;
                  tx_state_q <= StStart;
               end
            end
            StStart: begin
               if (tx_cnt_q == CntLast) begin
                  tx_cnt_q   <= '0;
                  tx_bit_q   <= '0;
                  txout_q    <= tx_shift_q[0];
                  tx_shift_q <= tx_shift_q >> 1;
                  tx_state_q <= StData;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            StData: begin
               if (tx_cnt_q == CntLast) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == BitLast) begin
`ifdef UART_PARITY_EN
                     txout_q    <= tx_par_q;
                     tx_state_q <= StParity;
`else
                     txout_q    <= 1'b1;
                     tx_state_q <= StStop;
`endif
                  end else begin
                     tx_bit_q   <= tx_bit_q + 1'b1;
                     txout_q    <= tx_shift_q[0];
                     tx_shift_q <= tx_shift_q >> 1;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
`ifdef UART_PARITY_EN
            StParity: begin
               if (tx_cnt_q == CntLast) begin
                  tx_cnt_q   <= '0;
                  txout_q    <= 1'b1;
                  tx_state_q <= StStop;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
`endif
            StStop: begin
               if (tx_cnt_q == CntLast) begin
                  tx_cnt_q   <= '0;
                  tx_busy_q  <= 1'b0;
                  tx_state_q <= StIdle;
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            default: begin
               txout_q    <= 1'b1;
               tx_busy_q  <= 1'b0;
               tx_state_q <= StIdle;
            end
         endcase
      end
   end

   logic [1:0]        sync_q;
   logic              rx_s;
   uart_state_e       rx_state_q;
   logic [CntW-1:0]   rx_cnt_q;
   logic [BitW-1:0]   rx_bit_q;
   logic [DATA_W-1:0] rx_shift_q;
   logic              rx_push_q;
   logic              rx_ferr_q;
`ifdef UART_PARITY_EN
   logic              rx_perr_q;
`endif

   assign rx_s = sync_q[1];

   always_ff @(posedge clk) begin
      if (RESET) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], rxin};
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         rx_state_q <= StIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_push_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
         rx_perr_q  <= 1'b0;
`endif
      end else begin
         rx_push_q <= 1'b0;
         // Set terms below come later, so a same-cycle error beats clr_err.
         if (clr_err) begin
            rx_ferr_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_q <= 1'b0;
`endif
         end
         case (rx_state_q)
            StIdle: begin
               if (!rx_s) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= StStart;
               end
            end
            StStart: begin
               if (rx_cnt_q == CntHalf) begin
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_s ? StIdle : StData;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            StData: begin
               if (rx_cnt_q == CntLast) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_s, rx_shift_q[DATA_W-1:1]};
                  if (rx_bit_q == BitLast) begin
`ifdef UART_PARITY_EN
                     rx_state_q <= StParity;
`else
                     rx_state_q <= StStop;
`endif
                  end else begin
                     rx_bit_q <= rx_bit_q + 1'b1;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
`ifdef UART_PARITY_EN
            StParity: begin
               if (rx_cnt_q == CntLast) begin
                  rx_cnt_q <= '0;
                  if (rx_s != ^rx_shift_q) rx_perr_q <= 1'b1;
                  rx_state_q <= StStop;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
`endif
            StStop: begin
               if (rx_cnt_q == CntLast) begin
                  rx_cnt_q <= '0;
                  if (rx_s) begin
                     rx_push_q  <= 1'b1;
                     rx_state_q <= StIdle;
                  end else begin
                     rx_ferr_q  <= 1'b1;
                     rx_state_q <= StBreak;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            StBreak: begin
               if (rx_s) rx_state_q <= StIdle;
            end
            default: rx_state_q <= StIdle;
         endcase
      end
   end

   logic fifo_empty;
   logic fifo_ovf;
   logic unused_fifo_full;
   logic rx_ovf_q;

   uart_rx_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk_i   (clk),
      .rst_i   (RESET),
      .push_i  (rx_push_q),
      .pop_i   (OSOUT),
      .wdata_i (rx_shift_q),
      .rdata_o (rx_data),
      .empty_o (fifo_empty),
      .full_o  (unused_fifo_full),
      .ovf_o   (fifo_ovf)
   );

   always_ff @(posedge clk) begin
      if (RESET) begin
         rx_ovf_q <= 1'b0;
      end else begin
         if (clr_err)  rx_ovf_q <= 1'b0;
         if (fifo_ovf) rx_ovf_q <= 1'b1;
      end
   end

   assign txout   = txout_q;
   assign TXF     = tx_busy_q;
   assign RXF     = !fifo_empty;
   assign rx_ovf  = rx_ovf_q;
   assign rx_ferr = rx_ferr_q;
`ifdef UART_PARITY_EN
   assign rx_perr = rx_perr_q;
`else
   assign rx_perr = 1'b0;
`endif

endmodule
